fetch_unit: RTL

- Instruction-fetch stage, directly downstream of the phase counter (rolling_counter). Consumes its `state` output as the current instruction phase.
- Owns the program counter (PC) and the instruction register (IR).
- Issues one synchronous instruction-memory read per instruction, latches the result, and advances or redirects the PC at end of instruction.
- Feeds decode/execute; a sticky halt stops all further fetches.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/fetch_unit_if.sv | 16 +
 rtl/fetch_unit_pc_next.sv | 31 +++
 rtl/fetch_unit.sv | 118 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage and the phase counter that drives it.
// Holds bus widths, the per-instruction phase numbering, the reset PC, the phase
// type shared with rolling_counter, and a saturating counter helper.
package cpu_pkg;

    localparam int ADDR_WIDTH  = 16;
    localparam int INSTR_WIDTH = 16;
    localparam int PHASE_COUNT = 4;
    localparam int PHASE_BITS  = $clog2(PHASE_COUNT);

    // Named instruction phases
    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_EXEC   = 2;
    localparam int PH_WB     = 3;

    localparam logic [ADDR_WIDTH-1:0] RESET_PC = 16'h0000;

    typedef logic [PHASE_BITS-1:0] phase_t;

    // 32-bit increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch stage (master) and a synchronous RAM
// (slave).
//   imem_re    : read enable, master -> slave
//   imem_addr  : read address, master -> slave
//   imem_rdata : read data, slave -> master, valid the cycle after imem_re
interface fetch_unit_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 16
);
    logic                   imem_re;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    modport master (output imem_re, output imem_addr, input  imem_rdata);
    modport slave  (input  imem_re, input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC select for the end of an instruction.
//   pc            : current program counter
//   halt          : halting instruction, PC holds
//   branch_taken  : redirect to branch_target (halt has priority)
//   branch_target : redirect address
//   next_pc       : selected PC; sequential fetch wraps modulo 2^ADDR_WIDTH
module pc_next
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  halt,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] next_pc
);

    // Priority select: halt holds, then branch, then sequential increment
    always_comb begin
        next_pc = pc;
        if (halt) begin
            next_pc = pc;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end else begin
            next_pc = pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC and the instruction register, issues one
// synchronous memory read per instruction and advances/redirects the PC at the end
// of each instruction. A halt instruction stops all further fetches until reset.
//   clk, reset    : clock and synchronous active-high reset
//   phase         : current instruction phase from the phase counter
//   imem          : instruction-memory read bus (master side)
//   branch_taken  : redirect request, only looked at in the update phase
//   branch_target : redirect address
//   halt_req      : halt request, only looked at in the update phase
//   pc, ir        : program counter and instruction register
//   ir_valid      : ir holds the instruction currently executing
//   halted        : sticky halt flag
//   retired       : saturating count of completed instructions
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH   = cpu_pkg::ADDR_WIDTH,
    parameter int INSTR_WIDTH  = cpu_pkg::INSTR_WIDTH,
    parameter int PHASE_COUNT  = cpu_pkg::PHASE_COUNT,
    parameter int PHASE_BITS   = $clog2(PHASE_COUNT),
    parameter int FETCH_PHASE  = cpu_pkg::PH_FETCH,
    parameter int UPDATE_PHASE = cpu_pkg::PH_WB,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(cpu_pkg::RESET_PC)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PHASE_BITS-1:0]  phase,
    fetch_unit_if.master           imem,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    input  logic                   halt_req,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic [INSTR_WIDTH-1:0] ir,
    output logic                   ir_valid,
    output logic                   halted,
    output logic [31:0]            retired
);

    // Read data returns on the edge that ends the phase after the fetch
    localparam int LATCH_PHASE = (FETCH_PHASE + 1) % PHASE_COUNT;

    localparam logic [PHASE_BITS-1:0] FETCH_PH  = PHASE_BITS'(FETCH_PHASE);
    localparam logic [PHASE_BITS-1:0] LATCH_PH  = PHASE_BITS'(LATCH_PHASE);
    localparam logic [PHASE_BITS-1:0] UPDATE_PH = PHASE_BITS'(UPDATE_PHASE);

    if (PHASE_COUNT < 3) begin : g_err_phase_count
        $error("fetch_unit: PHASE_COUNT must be at least 3");
    end
    if (UPDATE_PHASE == FETCH_PHASE) begin : g_err_update_fetch
        $error("fetch_unit: UPDATE_PHASE must differ from FETCH_PHASE");
    end
    if (UPDATE_PHASE == LATCH_PHASE) begin : g_err_update_latch
        $error("fetch_unit: UPDATE_PHASE must differ from the latch phase");
    end

    logic [ADDR_WIDTH-1:0]  pc_r;
    logic [INSTR_WIDTH-1:0] ir_r;
    logic                   ir_valid_r;
    logic                   halted_r;
    logic [31:0]            retired_r;

    logic [ADDR_WIDTH-1:0]  pc_next_s;
    logic                   is_fetch_s;
    logic                   is_latch_s;
    logic                   is_update_s;

    // Phase decode; out-of-range phase values match nothing
    always_comb begin
        is_fetch_s  = (phase == FETCH_PH);
        is_latch_s  = (phase == LATCH_PH);
        is_update_s = (phase == UPDATE_PH);
    end

    // Memory sees the address in the fetch phase with no registered latency
    assign imem.imem_re   = is_fetch_s & ~halted_r;
    assign imem.imem_addr = pc_r;

    pc_next #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pc_next (
        .pc            (pc_r),
        .halt          (halt_req),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (pc_next_s)
    );

    // PC / IR / halt / retire state; nothing moves while halted
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r       <= RESET_PC;
            ir_r       <= {INSTR_WIDTH{1'b0}};
            ir_valid_r <= 1'b0;
            halted_r   <= 1'b0;
            retired_r  <= 32'd0;
        end else if (!halted_r) begin
            if (is_latch_s) begin
                ir_r       <= imem.imem_rdata;
                ir_valid_r <= 1'b1;
            end else if (is_update_s) begin
                // pc_next already holds the PC when halt_req is set
                pc_r       <= pc_next_s;
                ir_valid_r <= 1'b0;
                retired_r  <= sat_inc32(retired_r);
                if (halt_req) begin
                    halted_r <= 1'b1;
                end
            end
        end
    end

    assign pc       = pc_r;
    assign ir       = ir_r;
    assign ir_valid = ir_valid_r;
    assign halted   = halted_r;
    assign retired  = retired_r;

endmodule
